// File: rtl/mult_arbiter_if.sv
// Client and multmod handshake bundle for mult_arbiter.
// slave = arbiter side, master = environment (clients + multmod) side.
interface mult_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
);
  logic [NREQ*255-1:0] cl_x;
  logic [NREQ*255-1:0] cl_y;
  logic [NREQ-1:0]     cl_req_valid;
  logic [NREQ-1:0]     cl_req_ready;
  logic [NREQ-1:0]     cl_req_busy;
  logic [NREQ-1:0]     cl_res_valid;
  logic [NREQ-1:0]     cl_res_ready;
  logic [254:0]        cl_z;
  logic [254:0]        m_x;
  logic [254:0]        m_y;
  logic [254:0]        m_z;
  logic                m_req_valid;
  logic                m_req_ready;
  logic                m_req_busy;
  logic                m_res_valid;
  logic                m_res_ready;
  logic [IDXW-1:0]     grant;

  modport slave (
    input  cl_x, cl_y, cl_req_valid, cl_res_ready,
    input  m_req_ready, m_req_busy, m_res_valid, m_z,
    output cl_req_ready, cl_req_busy, cl_res_valid, cl_z,
    output m_x, m_y, m_req_valid, m_res_ready, grant
  );

  modport master (
    output cl_x, cl_y, cl_req_valid, cl_res_ready,
    output m_req_ready, m_req_busy, m_res_valid, m_z,
    input  cl_req_ready, cl_req_busy, cl_res_valid, cl_z,
    input  m_x, m_y, m_req_valid, m_res_ready, grant
  );
endinterface

// File: rtl/mult_arbiter.sv
// Shares one multmod among NREQ clients, one transaction in flight, round-robin grant.
// Define MULT_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead.
module mult_arbiter #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic          clk,
  input  logic          rst,
  mult_arbiter_if.slave bus
);

  typedef enum logic [1:0] {A_IDLE, A_ISSUE, A_WAIT, A_DELIVER} state_t;

  state_t          state, state_nx;
  logic [IDXW-1:0] grant_q, grant_d;
  logic [NREQ-1:0] busy_q, busy_d;
  logic [NREQ-1:0] rdy_q, rdy_d;
  logic [NREQ-1:0] resv_q, resv_d;
  logic [254:0]    z_q, z_d;
  logic            mreqv_q, mreqv_d;
  logic            mresr_q, mresr_d;
  logic [IDXW-1:0] win, idx;
  logic            any_req;
  logic [254:0]    x_arr [NREQ];
  logic [254:0]    y_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign x_arr[g] = bus.cl_x[255*g +: 255];
    assign y_arr[g] = bus.cl_y[255*g +: 255];
  end

  assign bus.m_x          = x_arr[grant_q];
  assign bus.m_y          = y_arr[grant_q];
  assign bus.grant        = grant_q;
  assign bus.cl_req_busy  = busy_q;
  assign bus.cl_req_ready = rdy_q;
  assign bus.cl_res_valid = resv_q;
  assign bus.cl_z         = z_q;
  assign bus.m_req_valid  = mreqv_q;
  assign bus.m_res_ready  = mresr_q;

  // Scan in reverse priority order so the last hit is the winner.
  always_comb begin
    win     = grant_q;
    idx     = '0;
    any_req = |bus.cl_req_valid;
`ifdef MULT_ARB_FIXED_PRIO_EN
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDXW'(k);
      if (bus.cl_req_valid[idx]) win = idx;
    end
`else
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDXW'((int'(grant_q) + k) % NREQ);
      if (bus.cl_req_valid[idx]) win = idx;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= A_IDLE;
      grant_q <= IDXW'(NREQ - 1);
      busy_q  <= '0;
      rdy_q   <= '0;
      resv_q  <= '0;
      z_q     <= '0;
      mreqv_q <= 1'b0;
      mresr_q <= 1'b0;
    end else begin
      state   <= state_nx;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      resv_q  <= resv_d;
      z_q     <= z_d;
      mreqv_q <= mreqv_d;
      mresr_q <= mresr_d;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      A_IDLE:    if (any_req) state_nx = A_ISSUE;
      A_ISSUE:   if (bus.m_req_ready && mreqv_q) state_nx = A_WAIT;
      A_WAIT:    if (!bus.m_req_busy && bus.m_res_valid) state_nx = A_DELIVER;
      A_DELIVER: if (bus.cl_res_ready[grant_q]) state_nx = A_IDLE;
      default:   state_nx = A_IDLE;
    endcase
  end

  // Handshake only counts once our valid is actually on the bus.
  always_comb begin
    grant_d = grant_q;
    busy_d  = busy_q;
    rdy_d   = '0;
    resv_d  = resv_q;
    z_d     = z_q;
    mreqv_d = mreqv_q;
    mresr_d = mresr_q;
    case (state)
      A_IDLE: begin
        if (any_req) begin
          grant_d     = win;
          busy_d[win] = 1'b1;
        end
      end
      A_ISSUE: begin
        mresr_d = 1'b0;
        mreqv_d = 1'b1;
        if (bus.m_req_ready && mreqv_q) begin
          mreqv_d        = 1'b0;
          rdy_d[grant_q] = 1'b1;
        end
      end
      A_WAIT: begin
        if (!bus.m_req_busy && bus.m_res_valid) begin
          z_d             = bus.m_z;
          mresr_d         = 1'b1;
          resv_d[grant_q] = 1'b1;
        end
      end
      A_DELIVER: begin
        if (bus.cl_res_ready[grant_q]) begin
          resv_d[grant_q] = 1'b0;
          busy_d[grant_q] = 1'b0;
        end
      end
      default: ;
    endcase
  end

  a_busy_1h: assert property (@(posedge clk) disable iff (rst) $onehot0(busy_q));
  a_rdy_1h:  assert property (@(posedge clk) disable iff (rst) $onehot0(rdy_q));
  a_resv_1h: assert property (@(posedge clk) disable iff (rst) $onehot0(resv_q));

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed bench for mult_arbiter with a behavioural multmod (fixed latency, exact mod-p product).
module tb_mult_arbiter;
  localparam int NREQ = 4;
  localparam int IDXW = 2;
  localparam int LAT  = 5;
  localparam logic [254:0] P = {255{1'b1}} - 255'd18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_arbiter_if #(.NREQ(NREQ), .IDXW(IDXW)) bus();
  mult_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int total = 0;
  int bad   = 0;

  function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
    logic [511:0] w;
    w = 512'(a) * 512'(b);
    w = w % 512'(P);
    return w[254:0];
  endfunction

  // multmod model
  int cnt;
  always @(posedge clk) begin
    if (rst) begin
      bus.m_req_ready <= 1'b0;
      bus.m_req_busy  <= 1'b0;
      bus.m_res_valid <= 1'b0;
      bus.m_z         <= '0;
      cnt             <= 0;
    end else begin
      bus.m_req_ready <= 1'b0;
      if (!bus.m_req_busy && !bus.m_res_valid && bus.m_req_valid && !bus.m_req_ready)
        bus.m_req_ready <= 1'b1;
      if (bus.m_req_ready && bus.m_req_valid) begin
        bus.m_z        <= mulmod(bus.m_x, bus.m_y);
        bus.m_req_busy <= 1'b1;
        cnt            <= LAT;
      end else if (bus.m_req_busy) begin
        if (cnt == 1) begin
          bus.m_req_busy  <= 1'b0;
          bus.m_res_valid <= 1'b1;
        end
        cnt <= cnt - 1;
      end
      if (bus.m_res_valid && bus.m_res_ready) bus.m_res_valid <= 1'b0;
    end
  end

  logic            mon_en = 1'b0;
  logic [NREQ-1:0] mon_mask = '0;
  logic [NREQ-1:0] others_seen;
  always @(negedge clk) begin
    if (!mon_en) others_seen <= '0;
    else others_seen <= others_seen |
      ((bus.cl_req_ready | bus.cl_req_busy | bus.cl_res_valid) & mon_mask);
  end

  task automatic chk(input string tag, input logic [254:0] obs, input logic [254:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [254:0] x, input logic [254:0] y);
    bus.cl_x[255*i +: 255] = x;
    bus.cl_y[255*i +: 255] = y;
  endtask

  // kind 0: wait for cl_req_ready[i]; kind 1: wait for cl_res_valid[i]
  task automatic wait_for(input int kind, input int i, input string tag);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      seen = (kind == 0) ? bus.cl_req_ready[i] : bus.cl_res_valid[i];
    end
    chk(tag, 255'(seen), 255'd1);
  endtask

  task automatic ack(input logic [NREQ-1:0] m);
    bus.cl_res_ready = m;
    @(negedge clk);
    bus.cl_res_ready = '0;
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_req_ready"}, 255'(bus.cl_req_ready), 255'd0);
    chk({pfx, "_busy"},      255'(bus.cl_req_busy),  255'd0);
    chk({pfx, "_res_valid"}, 255'(bus.cl_res_valid), 255'd0);
    chk({pfx, "_z"},         bus.cl_z,               255'd0);
    chk({pfx, "_m_req_v"},   255'(bus.m_req_valid),  255'd0);
    chk({pfx, "_m_res_r"},   255'(bus.m_res_ready),  255'd0);
    chk({pfx, "_grant"},     255'(bus.grant),        255'd3);
  endtask

  int exp_ord [5];
  int drop_k;
  logic stall_bad;
  logic got;

  initial begin
    bus.cl_x = '0;
    bus.cl_y = '0;
    bus.cl_req_valid = '0;
    bus.cl_res_ready = '0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    rst = 1'b0;

    // single client 0: 3*5
    set_op(0, 255'd3, 255'd5);
    bus.cl_req_valid = 4'b0001;
    wait_for(0, 0, "t1_req_rdy");
    chk("t1_busy", 255'(bus.cl_req_busy), 255'd1);
    bus.cl_req_valid = '0;
    @(negedge clk);
    chk("t1_rdy_pulse", 255'(bus.cl_req_ready), 255'd0);
    wait_for(1, 0, "t1_res");
    chk("t1_z", bus.cl_z, 255'd15);
    chk("t1_grant", 255'(bus.grant), 255'd0);
    ack(4'b0001);
    chk("t1_busy_drop", 255'(bus.cl_req_busy), 255'd0);
    chk("t1_resv_drop", 255'(bus.cl_res_valid), 255'd0);

    // client 2: (p-1)^2 mod p = 1, others untouched
    mon_mask = 4'b1011;
    mon_en = 1'b1;
    set_op(2, P - 255'd1, P - 255'd1);
    bus.cl_req_valid = 4'b0100;
    wait_for(0, 2, "t2_req_rdy");
    bus.cl_req_valid = '0;
    wait_for(1, 2, "t2_res");
    chk("t2_z", bus.cl_z, 255'd1);
    chk("t2_grant", 255'(bus.grant), 255'd2);
    ack(4'b0100);
    @(negedge clk);
    chk("t2_isolation", 255'(others_seen), 255'd0);
    mon_en = 1'b0;

    // all four request continuously
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`ifdef MULT_ARB_FIXED_PRIO_EN
    exp_ord = '{0, 0, 1, 2, 3};
    drop_k  = 1;
`else
    exp_ord = '{0, 1, 2, 3, 0};
    drop_k  = -1;
`endif
    for (int i = 0; i < NREQ; i++) set_op(i, 255'(i + 2), 255'd7);
    bus.cl_req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      got = 1'b0;
      for (int c = 0; c < 200 && !got; c++) begin
        @(negedge clk);
        got = |bus.cl_res_valid;
      end
      chk($sformatf("t3_res_%0d", k), 255'(got), 255'd1);
      chk($sformatf("t3_grant_%0d", k), 255'(bus.grant), 255'(exp_ord[k]));
      chk($sformatf("t3_resv_%0d", k), 255'(bus.cl_res_valid), 255'(1 << exp_ord[k]));
      chk($sformatf("t3_z_%0d", k), bus.cl_z, 255'(7 * (exp_ord[k] + 2)));
      if (k == drop_k) bus.cl_req_valid[0] = 1'b0;
      if (k == 4) bus.cl_req_valid = '0;
      ack(4'b1111);
    end

    // result stall on client 1 blocks client 3
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_op(1, 255'd4, 255'd6);
    set_op(3, 255'd10, 255'd11);
    bus.cl_req_valid = 4'b0010;
    wait_for(1, 1, "t4_res1");
    bus.cl_req_valid = 4'b1000;
    stall_bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.cl_req_busy[3] || bus.cl_z !== 255'd24 || bus.cl_res_valid !== 4'b0010)
        stall_bad = 1'b1;
    end
    chk("t4_stall", 255'(stall_bad), 255'd0);
    chk("t4_grant1", 255'(bus.grant), 255'd1);
    ack(4'b0010);
    wait_for(1, 3, "t4_res3");
    chk("t4_z3", bus.cl_z, 255'd110);
    chk("t4_grant3", 255'(bus.grant), 255'd3);
    bus.cl_req_valid = '0;
    ack(4'b1000);

    // reset while waiting on multmod
    set_op(0, 255'd5, 255'd5);
    bus.cl_req_valid = 4'b0001;
    wait_for(0, 0, "t5_req_rdy");
    bus.cl_req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset("t5_rst");
    rst = 1'b0;
    set_op(0, 255'd9, 255'd9);
    bus.cl_req_valid = 4'b0001;
    wait_for(0, 0, "t5_req_rdy2");
    bus.cl_req_valid = '0;
    wait_for(1, 0, "t5_res");
    chk("t5_z", bus.cl_z, 255'd81);
    ack(4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
